// File: rtl/dac_chk_pkg.sv
// Shared types, constants and elaboration/compare helpers for the DAC waveform checker.
package dac_chk_pkg;

  typedef logic [9:0] dac_code_t;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  localparam int        DAC_MIDSCALE = 512;
  localparam int        DAC_MAX      = 1023;
  localparam dac_code_t MID_CODE     = 10'd512;
  localparam dac_code_t MAX_CODE     = 10'd1023;
  localparam real       PI           = 3.14159265358979323846;

  // Round a real to the nearest integer, halves away from zero.
  function automatic int round_real(real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(0.5 - x);
  endfunction

  // Turn a fractional tolerance into an integer code threshold.
  function automatic int round_thresh(real frac, int scale);
    return round_real(frac * real'(scale));
  endfunction

  // Saturate a signed intermediate onto the 10-bit DAC code range.
  function automatic dac_code_t clamp_code(int v);
    if (v < 0) return '0;
    if (v > DAC_MAX) return MAX_CODE;
    return dac_code_t'(v);
  endfunction

  // Magnitude of the difference between two DAC codes.
  function automatic dac_code_t abs_diff(dac_code_t a, dac_code_t b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/dac_wave_checker_if.sv
// DAC sample bus plus checker status, shared by the driving side and the checker.
interface dac_wave_checker_if;
  dac_chk_pkg::dac_code_t dac_data;
  logic                   locked;
  logic                   sin_ok;
  logic                   hann_ok;
  logic [31:0]            sample_cnt;
  logic [15:0]            err_sin;
  logic [15:0]            err_hann;
  logic [15:0]            err_base;

  modport master (
    output dac_data,
    input  locked, sin_ok, hann_ok, sample_cnt, err_sin, err_hann, err_base
  );

  modport slave (
    input  dac_data,
    output locked, sin_ok, hann_ok, sample_cnt, err_sin, err_hann, err_base
  );
endinterface

// File: rtl/dac_ref_lut.sv
// Reference tables: a full-period sine and the rising half of a Hann window,
// both built at elaboration, each read through a single output register.
module dac_ref_lut
  import dac_chk_pkg::*;
#(
  parameter int SIN_AMPL      = 512,
  parameter int SIN_LUT_SIZE  = 1024,
  parameter int HANN_AMPL     = 1024,
  parameter int HANN_LUT_SIZE = 64,
  parameter int SIN_AW        = $clog2(SIN_LUT_SIZE),
  parameter int HANN_AW       = $clog2(HANN_LUT_SIZE),
  parameter int WIN_W         = $clog2(HANN_AMPL + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SIN_AW-1:0]       sin_addr,
  input  logic [HANN_AW-1:0]      hann_addr,
  output logic signed [10:0]      sin_val,
  output logic [WIN_W-1:0]        win_val
);

  logic signed [10:0] sin_rom [SIN_LUT_SIZE];
  logic [WIN_W-1:0]   win_rom [HANN_LUT_SIZE];

  function automatic logic signed [10:0] sin_entry(int i);
    real phase;
    phase = 2.0 * PI * real'(i) / real'(SIN_LUT_SIZE);
    return 11'(round_real(real'(SIN_AMPL) * $sin(phase)));
  endfunction

  // The window is symmetric over 2*HANN_LUT_SIZE points, so only the rising half is kept.
  function automatic logic [WIN_W-1:0] win_entry(int k);
    real phase;
    phase = 2.0 * PI * real'(k) / real'(2 * HANN_LUT_SIZE - 1);
    return WIN_W'(round_real(real'(HANN_AMPL) * 0.5 * (1.0 - $cos(phase))));
  endfunction

  for (genvar g = 0; g < SIN_LUT_SIZE; g++) begin : g_sin
    assign sin_rom[g] = sin_entry(g);
  end

  for (genvar g = 0; g < HANN_LUT_SIZE; g++) begin : g_win
    assign win_rom[g] = win_entry(g);
  end

  // Registered table reads, aligned with the capture of the matching sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sin_val <= '0;
      win_val <= '0;
    end else begin
      sin_val <= sin_rom[sin_addr];
      win_val <= win_rom[hann_addr];
    end
  end

endmodule

// File: rtl/dac_wave_checker.sv
// Monitors the DAC output bus: locks at mid-scale, then scores every sample
// against a pure sine and a Hann-windowed sine with saturating error counters.
module dac_wave_checker
  import dac_chk_pkg::*;
#(
  parameter real BASE_TOLERANCE = 0.05,
  parameter real SIN_TOLERANCE  = 0.3,
  parameter real HANN_TOLERANCE = 0.35,
  parameter int  SCALE_FACTOR   = 1024,
  parameter int  SIN_AMPL       = 512,
  parameter int  SIN_LUT_SIZE   = 1024,
  parameter int  HANN_AMPL      = 1024,
  parameter int  HANN_LUT_SIZE  = 64
) (
  input logic               dac_clk_out,
  input logic               rst_n,
  dac_wave_checker_if.slave bus
);

  localparam int SIN_AW  = $clog2(SIN_LUT_SIZE);
  localparam int HANN_N  = 2 * HANN_LUT_SIZE;
  localparam int HANN_AW = $clog2(HANN_LUT_SIZE);
  localparam int HANN_IW = $clog2(HANN_N);
  localparam int WIN_W   = $clog2(HANN_AMPL + 1);
  localparam int PROD_W  = 11 + WIN_W + 1;

  localparam int T_BASE = round_thresh(BASE_TOLERANCE, SCALE_FACTOR);
  localparam int T_SIN  = round_thresh(SIN_TOLERANCE, SIN_AMPL);
  localparam int T_HANN = round_thresh(HANN_TOLERANCE, HANN_AMPL);

  localparam logic signed [PROD_W-1:0] HANN_DIV = PROD_W'(HANN_AMPL);

  lock_state_t        state, state_next;
  dac_code_t          d_q;
  logic               v_q;
  logic               lock_now, advance;
  logic [SIN_AW-1:0]  sin_idx, sin_next, sin_addr;
  logic [HANN_IW-1:0] hann_idx, hann_next, hann_addr;
  logic [HANN_AW-1:0] hann_fold;
  logic signed [10:0] s_q;
  logic [WIN_W-1:0]   w_q;
  logic signed [PROD_W-1:0] prod, quot;
  dac_code_t          exp_sin, exp_hann, e_s, e_h;
  logic               sin_hit, hann_hit, base_miss;
  logic               sin_ok, hann_ok;
  logic [31:0]        sample_cnt;
  logic [15:0]        err_sin, err_hann, err_base;

  dac_ref_lut #(
    .SIN_AMPL      (SIN_AMPL),
    .SIN_LUT_SIZE  (SIN_LUT_SIZE),
    .HANN_AMPL     (HANN_AMPL),
    .HANN_LUT_SIZE (HANN_LUT_SIZE),
    .SIN_AW        (SIN_AW),
    .HANN_AW       (HANN_AW),
    .WIN_W         (WIN_W)
  ) u_lut (
    .clk       (dac_clk_out),
    .rst_n     (rst_n),
    .sin_addr  (sin_addr),
    .hann_addr (hann_fold),
    .sin_val   (s_q),
    .win_val   (w_q)
  );

  // Lock FSM state register.
  always_ff @(posedge dac_clk_out or negedge rst_n) begin
    if (!rst_n) state <= UNLOCKED;
    else        state <= state_next;
  end

  // Lock decision: a captured sample near mid-scale locks and is itself checked as index 0.
  always_comb begin
    state_next = state;
    lock_now   = 1'b0;
    if (state == UNLOCKED && v_q && int'(abs_diff(d_q, MID_CODE)) <= T_BASE) begin
      lock_now   = 1'b1;
      state_next = LOCKED;
    end
    advance = v_q && (state == LOCKED || lock_now);
  end

  // Table address for the sample being captured this edge: next index once locked, else 0.
  always_comb begin
    sin_next  = (sin_idx == SIN_AW'(SIN_LUT_SIZE - 1)) ? '0 : sin_idx + SIN_AW'(1);
    hann_next = (hann_idx == HANN_IW'(HANN_N - 1)) ? '0 : hann_idx + HANN_IW'(1);
    sin_addr  = advance ? sin_next : '0;
    hann_addr = advance ? hann_next : '0;
    if (hann_addr < HANN_IW'(HANN_LUT_SIZE)) hann_fold = hann_addr[HANN_AW-1:0];
    else                                     hann_fold = HANN_AW'(HANN_IW'(HANN_N - 1) - hann_addr);
  end

  // Sample capture and index tracking; the valid bit drops any sample caught in reset.
  always_ff @(posedge dac_clk_out or negedge rst_n) begin
    if (!rst_n) begin
      d_q      <= '0;
      v_q      <= 1'b0;
      sin_idx  <= '0;
      hann_idx <= '0;
    end else begin
      d_q      <= bus.dac_data;
      v_q      <= 1'b1;
      sin_idx  <= sin_addr;
      hann_idx <= hann_addr;
    end
  end

  // Expected codes and tolerance tests; signed division truncates the window product toward zero.
  always_comb begin
    prod      = PROD_W'(s_q) * PROD_W'($signed({1'b0, w_q}));
    quot      = prod / HANN_DIV;
    exp_sin   = clamp_code(int'(s_q) + DAC_MIDSCALE);
    exp_hann  = clamp_code(int'(quot) + DAC_MIDSCALE);
    e_s       = abs_diff(d_q, exp_sin);
    e_h       = abs_diff(d_q, exp_hann);
    sin_hit   = int'(e_s) <= T_SIN;
    hann_hit  = int'(e_h) <= T_HANN;
    base_miss = (int'(e_s) > T_BASE) && (int'(e_h) > T_BASE);
  end

  // Per-sample flags and saturating statistics, updated only for checked samples.
  always_ff @(posedge dac_clk_out or negedge rst_n) begin
    if (!rst_n) begin
      sin_ok     <= 1'b0;
      hann_ok    <= 1'b0;
      sample_cnt <= '0;
      err_sin    <= '0;
      err_hann   <= '0;
      err_base   <= '0;
    end else if (advance) begin
      sin_ok  <= sin_hit;
      hann_ok <= hann_hit;
      if (sample_cnt != '1)             sample_cnt <= sample_cnt + 32'd1;
      if (!sin_hit && err_sin != '1)    err_sin    <= err_sin + 16'd1;
      if (!hann_hit && err_hann != '1)  err_hann   <= err_hann + 16'd1;
      if (base_miss && err_base != '1)  err_base   <= err_base + 16'd1;
    end
  end

  assign bus.locked     = (state == LOCKED);
  assign bus.sin_ok     = sin_ok;
  assign bus.hann_ok    = hann_ok;
  assign bus.sample_cnt = sample_cnt;
  assign bus.err_sin    = err_sin;
  assign bus.err_hann   = err_hann;
  assign bus.err_base   = err_base;

endmodule

// File: tb/tb_dac_wave_checker.sv
// Directed bench for dac_wave_checker: reset, ideal/windowed/faulted streams,
// lock threshold edge and counter saturation, scored against a real-valued model.
module tb_dac_wave_checker;

  localparam real PI = 3.14159265358979323846;

  logic clk;
  logic rst_n;
  dac_wave_checker_if bus();

  int vec_cnt, miss_cnt;
  int m_cnt, m_es, m_eh, m_eb;
  int low_cnt, low_idx, fault_idx;
  logic hann_at_fault;

  dac_wave_checker dut (
    .dac_clk_out (clk),
    .rst_n       (rst_n),
    .bus         (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int rnd(real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  function automatic int iabs(int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic int clamp10(int v);
    if (v < 0) return 0;
    if (v > 1023) return 1023;
    return v;
  endfunction

  function automatic int model_s(int i);
    return rnd(512.0 * $sin(2.0 * PI * real'(i % 1024) / 1024.0));
  endfunction

  function automatic int model_w(int k);
    int kk;
    kk = k % 128;
    if (kk >= 64) kk = 127 - kk;
    return rnd(512.0 * (1.0 - $cos(2.0 * PI * real'(kk) / 127.0)));
  endfunction

  function automatic int exp_sin(int i);
    return clamp10(512 + model_s(i));
  endfunction

  function automatic int exp_hann(int i);
    return clamp10(512 + $rtoi(real'(model_s(i) * model_w(i)) / 1024.0));
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.dac_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_cnt = 0; m_es = 0; m_eh = 0; m_eb = 0;
    low_cnt = 0; low_idx = -1; hann_at_fault = 1'b0;
  endtask

  // Score one locked sample's flags against the model and advance model counters.
  task automatic observe(input int idx, input int d, input bit flag_checks);
    int es, eh;
    es = iabs(d - exp_sin(idx));
    eh = iabs(d - exp_hann(idx));
    m_cnt++;
    if (es > 154 && m_es < 65535) m_es++;
    if (eh > 358 && m_eh < 65535) m_eh++;
    if (es > 51 && eh > 51 && m_eb < 65535) m_eb++;
    if (flag_checks) begin
      checkOutput("sin_ok", 64'(bus.sin_ok), 64'(es <= 154));
      checkOutput("hann_ok", 64'(bus.hann_ok), 64'(eh <= 358));
    end
    if (bus.sin_ok !== 1'b1) begin
      low_cnt++;
      low_idx = idx;
    end
    if (idx == fault_idx) hann_at_fault = bus.hann_ok;
  endtask

  // mode 0: ideal sine, 1: ideal windowed sine, 2: lock then always far from the sine.
  task automatic applyStimulus(input int mode, input int n, input int f_at, input int f_val,
                               input bit flag_checks);
    int d_hist[4];
    int d;
    for (int j = 0; j < n + 2; j++) begin
      @(negedge clk);
      if (j >= 2) observe(j - 2, d_hist[(j - 2) % 4], flag_checks);
      if (j < n) begin
        case (mode)
          0:       d = (j == f_at) ? f_val : exp_sin(j);
          1:       d = exp_hann(j);
          default: d = (j == 0) ? 512 : ((exp_sin(j) < 512) ? 1023 : 0);
        endcase
        d_hist[j % 4] = d;
        bus.dac_data = 10'(d);
      end
    end
  endtask

  initial begin
    vec_cnt = 0; miss_cnt = 0;
    m_cnt = 0; m_es = 0; m_eh = 0; m_eb = 0;
    low_cnt = 0; low_idx = -1; fault_idx = -1; hann_at_fault = 1'b0;
    rst_n = 1'b0;
    bus.dac_data = '0;

    #1;
    checkOutput("por_locked", 64'(bus.locked), 64'd0);
    checkOutput("por_sample_cnt", 64'(bus.sample_cnt), 64'd0);
    checkOutput("por_err_sin", 64'(bus.err_sin), 64'd0);

    $display("[TB] mid-stream reset");
    apply_reset();
    applyStimulus(0, 100, -1, 0, 1'b1);
    checkOutput("pre_rst_locked", 64'(bus.locked), 64'd1);
    checkOutput("pre_rst_sample_cnt", 64'(bus.sample_cnt), 64'd100);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_locked", 64'(bus.locked), 64'd0);
    checkOutput("rst_sin_ok", 64'(bus.sin_ok), 64'd0);
    checkOutput("rst_hann_ok", 64'(bus.hann_ok), 64'd0);
    checkOutput("rst_sample_cnt", 64'(bus.sample_cnt), 64'd0);
    checkOutput("rst_err_sin", 64'(bus.err_sin), 64'd0);
    checkOutput("rst_err_hann", 64'(bus.err_hann), 64'd0);
    checkOutput("rst_err_base", 64'(bus.err_base), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.dac_data = '0;
    repeat (10) @(negedge clk);
    checkOutput("zero_locked", 64'(bus.locked), 64'd0);
    checkOutput("zero_sample_cnt", 64'(bus.sample_cnt), 64'd0);
    checkOutput("zero_err_sin", 64'(bus.err_sin), 64'd0);
    checkOutput("zero_err_hann", 64'(bus.err_hann), 64'd0);
    checkOutput("zero_err_base", 64'(bus.err_base), 64'd0);

    $display("[TB] ideal sine");
    apply_reset();
    applyStimulus(0, 1024, -1, 0, 1'b1);
    checkOutput("sine_locked", 64'(bus.locked), 64'd1);
    checkOutput("sine_sample_cnt", 64'(bus.sample_cnt), 64'd1024);
    checkOutput("sine_err_sin", 64'(bus.err_sin), 64'd0);
    checkOutput("sine_err_base", 64'(bus.err_base), 64'd0);
    checkOutput("sine_err_hann_nonzero", 64'(bus.err_hann > 16'd0), 64'd1);
    checkOutput("sine_err_hann", 64'(bus.err_hann), 64'(m_eh));
    checkOutput("sine_ok_low_cycles", 64'(low_cnt), 64'd0);

    $display("[TB] ideal windowed sine");
    apply_reset();
    applyStimulus(1, 1024, -1, 0, 1'b1);
    checkOutput("hann_sample_cnt", 64'(bus.sample_cnt), 64'd1024);
    checkOutput("hann_err_hann", 64'(bus.err_hann), 64'd0);
    checkOutput("hann_err_base", 64'(bus.err_base), 64'd0);
    checkOutput("hann_err_sin", 64'(bus.err_sin), 64'(m_es));

    $display("[TB] single fault at sample 512");
    apply_reset();
    fault_idx = 512;
    applyStimulus(0, 1024, 512, 712, 1'b1);
    checkOutput("fault_err_sin", 64'(bus.err_sin), 64'd1);
    checkOutput("fault_err_base", 64'(bus.err_base), 64'd1);
    checkOutput("fault_err_hann", 64'(bus.err_hann), 64'(m_eh));
    checkOutput("fault_ok_low_cycles", 64'(low_cnt), 64'd1);
    checkOutput("fault_ok_low_index", 64'(low_idx), 64'd512);
    checkOutput("fault_hann_ok", 64'(hann_at_fault), 64'd1);
    fault_idx = -1;

    $display("[TB] lock threshold");
    apply_reset();
    @(negedge clk); bus.dac_data = 10'd460;
    @(negedge clk); bus.dac_data = 10'd461;
    @(negedge clk); bus.dac_data = 10'(exp_sin(1));
    checkOutput("bound460_locked", 64'(bus.locked), 64'd0);
    checkOutput("bound460_sample_cnt", 64'(bus.sample_cnt), 64'd0);
    @(negedge clk); bus.dac_data = 10'(exp_sin(2));
    checkOutput("bound461_locked", 64'(bus.locked), 64'd1);
    checkOutput("bound461_sample_cnt", 64'(bus.sample_cnt), 64'd1);
    checkOutput("bound461_sin_ok", 64'(bus.sin_ok), 64'd1);
    checkOutput("bound461_err_base", 64'(bus.err_base), 64'd0);

    $display("[TB] counter saturation");
    apply_reset();
    applyStimulus(2, 70001, -1, 0, 1'b0);
    checkOutput("sat_err_sin", 64'(bus.err_sin), 64'd65535);
    checkOutput("sat_sample_cnt", 64'(bus.sample_cnt), 64'd70001);
    checkOutput("sat_sin_ok", 64'(bus.sin_ok), 64'd0);
    checkOutput("sat_err_hann", 64'(bus.err_hann), 64'(m_eh));
    checkOutput("sat_err_base", 64'(bus.err_base), 64'(m_eb));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
